fetch_stage: RTL and testbench

//  Instruction-fetch stage for the pipelined RV32I core. Owns the PC, issues one-at-a-time requests to a

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 49 ++++
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the RV32I instruction-fetch
//               stage (FSM state encoding, NOP encoding, default width).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Default data/address width of the fetch path
  localparam int unsigned FETCH_WIDTH = 32;

  // addi x0, x0, 0 -- canonical RV32I NOP, used as the IF/ID bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // first cycle after reset release
    REQ  = 2'd1,  // request presented, waiting for imem_ready
    WAIT = 2'd2,  // request accepted, waiting for imem_rvalid
    HOLD = 2'd3   // response parked in skid buffer while decode stalls
  } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Priority: flush > load > stall-hold.
//               With none of these, the register turns into a bubble so that
//               an instruction already handed to decode is not issued twice.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = FETCH_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] instr_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] pc_plus4_in,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_plus4_d,
  output logic             valid_d
);

  localparam logic [WIDTH-1:0] NOP = WIDTH'(NOP_INSTR);

  // IF/ID contents; pc_d/pc_plus4_d are kept on flush/bubble (don't-care then)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush || (!load && !stall)) begin
      instr_d <= NOP;
      valid_d <= 1'b0;
    end else if (load) begin
      instr_d    <= instr_in;
      pc_d       <= pc_in;
      pc_plus4_d <= pc_plus4_in;
      valid_d    <= 1'b1;
    end
  end

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction-fetch stage. Owns the PC, issues at most one
//               outstanding request to a variable-latency instruction memory,
//               parks a response in a skid buffer when decode stalls, and
//               handles redirects by flushing IF/ID and killing the in-flight
//               response.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = FETCH_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall,
  input  logic             pc_src,
  input  logic [WIDTH-1:0] pc_target,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_plus4_d,
  output logic             valid_d
);

  fetch_state_t     state, state_next;
  logic [WIDTH-1:0] pc_f, pc_next;
  logic [WIDTH-1:0] pc_plus4_f;
  logic [WIDTH-1:0] target_aligned;
  logic             kill, kill_next;
  logic [WIDTH-1:0] skid_q;
  logic             skid_we;
  logic             ifid_load;
  logic             ifid_from_skid;
  logic [WIDTH-1:0] ifid_instr;
  logic             unused_target_lsbs;

  // Redirect targets are always word aligned; the two low bits are dropped
  assign target_aligned     = {pc_target[WIDTH-1:2], 2'b00};
  assign unused_target_lsbs = ^pc_target[1:0];
  assign pc_plus4_f         = pc_f + WIDTH'(4);

  // The request address is the fetch PC itself; it only moves in REQ on redirect
  assign imem_req   = (state == REQ);
  assign imem_addr  = pc_f;
  assign ifid_instr = ifid_from_skid ? skid_q : imem_rdata;

  // Sequencer state, fetch PC, kill flag and skid buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc_f   <= RESET_PC;
      kill   <= 1'b0;
      skid_q <= '0;
    end else begin
      state <= state_next;
      pc_f  <= pc_next;
      kill  <= kill_next;
      if (skid_we) begin
        skid_q <= imem_rdata;
      end
    end
  end

  // Next-state, next-PC and IF/ID load decisions; redirect beats stall
  always_comb begin
    state_next     = state;
    pc_next        = pc_f;
    kill_next      = kill;
    skid_we        = 1'b0;
    ifid_load      = 1'b0;
    ifid_from_skid = 1'b0;
    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        if (pc_src) begin
          pc_next = target_aligned;
        end
        if (imem_ready) begin
          state_next = WAIT;
          // Request went out on the wrong path: its response must be dropped
          if (pc_src) begin
            kill_next = 1'b1;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill || pc_src) begin
            // Wrong-path data; on a killed response pc_f already holds the target
            kill_next  = 1'b0;
            state_next = REQ;
            if (pc_src) begin
              pc_next = target_aligned;
            end
          end else if (!stall || !valid_d) begin
            ifid_load  = 1'b1;
            pc_next    = pc_plus4_f;
            state_next = REQ;
          end else begin
            skid_we    = 1'b1;
            state_next = HOLD;
          end
        end else if (pc_src) begin
          kill_next = 1'b1;
          pc_next   = target_aligned;
        end
      end
      HOLD: begin
        if (pc_src) begin
          pc_next    = target_aligned;
          state_next = REQ;
        end else if (!stall) begin
          ifid_load      = 1'b1;
          ifid_from_skid = 1'b1;
          pc_next        = pc_plus4_f;
          state_next     = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  if_id_reg #(
    .WIDTH (WIDTH)
  ) u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ifid_load),
    .stall       (stall),
    .flush       (pc_src),
    .instr_in    (ifid_instr),
    .pc_in       (pc_f),
    .pc_plus4_in (pc_plus4_f),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d)
  );

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed, self-checking bench for fetch_stage with a small
//               instruction-memory model of programmable response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  int checks = 0;
  int errors = 0;

  // memory model state
  int          mem_lat = 1;
  logic        pend    = 1'b0;
  int          cnt     = 0;
  logic [31:0] paddr   = '0;
  logic [31:0] last_hs_addr = '0;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word stored at a given address (distinct per address)
  function automatic logic [31:0] instr_for(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One clock: handshake seen at the edge is queued, responses are driven after negedge
  task automatic step();
    logic        hs;
    logic [31:0] a;
    hs = imem_req && imem_ready;
    a  = imem_addr;
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = 1'b0;
    if (hs) begin
      pend = 1'b1;
      cnt  = mem_lat;
      paddr = a;
      last_hs_addr = a;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_for(paddr);
        pend        = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic        stall;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // stall ready | req addr valid pc pc4 instr
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00, NOP};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00, NOP};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00, 32'h04, 32'hA500_0000};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h04, 1'b0, 32'h00, 32'h04, NOP};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04, 32'h08, 32'hA500_0004};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h08, 1'b0, 32'h04, 32'h08, NOP};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08, 32'h0C, 32'hA500_0008};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h08, 32'h0C, 32'hA500_0008};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h08, 32'h0C, 32'hA500_0008};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h08, 32'h0C, 32'hA500_0008};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C, 32'h10, 32'hA500_000C};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0C, 32'h10, NOP};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10, 32'h14, 32'hA500_0010};

    rst_n       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    stall       = 1'b0;
    pc_src      = 1'b0;
    pc_target   = '0;

    repeat (2) @(negedge clk);
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", instr_d, NOP);
    chk("rst_pc",    pc_d, 32'h0);
    chk("rst_pc4",   pc_plus4_d, 32'h0);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    rst_n = 1'b1;

    // Sequential fetch (0,4,8) and a 3-cycle stall with the response parked
    for (int k = 0; k < 13; k++) begin
      stall      = tbl[k].stall;
      imem_ready = tbl[k].ready;
      pc_src     = 1'b0;
      step();
      chk($sformatf("r%0d_req", k),   {31'd0, imem_req}, {31'd0, tbl[k].req});
      chk($sformatf("r%0d_addr", k),  imem_addr, tbl[k].addr);
      chk($sformatf("r%0d_valid", k), {31'd0, valid_d}, {31'd0, tbl[k].valid});
      chk($sformatf("r%0d_pc", k),    pc_d, tbl[k].pc);
      chk($sformatf("r%0d_pc4", k),   pc_plus4_d, tbl[k].pc4);
      chk($sformatf("r%0d_instr", k), instr_d, tbl[k].instr);
    end

    // Redirect while waiting (latency 2): response for 0x14 must be dropped
    mem_lat = 2;
    stall   = 1'b1;
    step();
    chk("t3_wait_req",   {31'd0, imem_req}, 32'd0);
    chk("t3_hold_valid", {31'd0, valid_d}, 32'd1);
    pc_src    = 1'b1;
    pc_target = 32'h0000_0102;
    step();
    chk("t3_flush_valid", {31'd0, valid_d}, 32'd0);
    chk("t3_flush_instr", instr_d, NOP);
    chk("t3_flush_pc",    pc_d, 32'h10);
    chk("t3_flush_req",   {31'd0, imem_req}, 32'd0);
    pc_src = 1'b0;
    stall  = 1'b0;
    step();
    chk("t3_req",   {31'd0, imem_req}, 32'd1);
    chk("t3_addr",  imem_addr, 32'h100);
    chk("t3_instr", instr_d, NOP);
    step();
    chk("t3_hs_addr", last_hs_addr, 32'h100);
    step();
    chk("t3_lat_valid", {31'd0, valid_d}, 32'd0);
    step();
    chk("t3_ld_valid", {31'd0, valid_d}, 32'd1);
    chk("t3_ld_pc",    pc_d, 32'h100);
    chk("t3_ld_instr", instr_d, 32'hA500_0100);
    chk("t3_next",     imem_addr, 32'h104);
    mem_lat = 1;

    // Redirect in the same cycle as the response
    step();
    pc_src    = 1'b1;
    pc_target = 32'h0000_0200;
    step();
    chk("t4_req",   {31'd0, imem_req}, 32'd1);
    chk("t4_addr",  imem_addr, 32'h200);
    chk("t4_valid", {31'd0, valid_d}, 32'd0);
    chk("t4_instr", instr_d, NOP);
    pc_src = 1'b0;
    step();
    step();
    chk("t4_ld_pc",    pc_d, 32'h200);
    chk("t4_ld_instr", instr_d, 32'hA500_0200);

    // Memory not ready: address held, then redirected while still unaccepted
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t5_req%0d", k),  {31'd0, imem_req}, 32'd1);
      chk($sformatf("t5_addr%0d", k), imem_addr, 32'h204);
    end
    pc_src    = 1'b1;
    pc_target = 32'h0000_0300;
    step();
    chk("t5_redir_req",  {31'd0, imem_req}, 32'd1);
    chk("t5_redir_addr", imem_addr, 32'h300);
    pc_src     = 1'b0;
    imem_ready = 1'b1;
    step();
    chk("t5_hs_addr", last_hs_addr, 32'h300);
    step();
    chk("t5_ld_pc",    pc_d, 32'h300);
    chk("t5_ld_instr", instr_d, 32'hA500_0300);

    // Redirect coinciding with the handshake: the accepted request is killed
    pc_src    = 1'b1;
    pc_target = 32'h0000_0400;
    step();
    chk("t5k_hs_addr", last_hs_addr, 32'h304);
    chk("t5k_req",     {31'd0, imem_req}, 32'd0);
    pc_src = 1'b0;
    step();
    chk("t5k_addr",  imem_addr, 32'h400);
    chk("t5k_instr", instr_d, NOP);
    step();
    step();
    chk("t5k_ld_pc",    pc_d, 32'h400);
    chk("t5k_ld_instr", instr_d, 32'hA500_0400);

    // Asynchronous reset in the middle of a wait
    mem_lat = 2;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req",   {31'd0, imem_req}, 32'd0);
    chk("t6_addr",  imem_addr, 32'h0);
    chk("t6_valid", {31'd0, valid_d}, 32'd0);
    chk("t6_instr", instr_d, NOP);
    chk("t6_pc",    pc_d, 32'h0);
    chk("t6_pc4",   pc_plus4_d, 32'h0);
    pend        = 1'b0;
    imem_rvalid = 1'b0;
    mem_lat     = 1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_refetch_req",  {31'd0, imem_req}, 32'd1);
    chk("t6_refetch_addr", imem_addr, 32'h0);
    step();
    step();
    chk("t6_ld_pc",    pc_d, 32'h0);
    chk("t6_ld_instr", instr_d, 32'hA500_0000);
    chk("t6_ld_valid", {31'd0, valid_d}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
